mcu_spi_target: RTL and testbench
=================================

Name: mcu_spi_target

Overview:
- Memory-mapped SPI target (slave) peripheral, the receiving end of the MCU SPI master link: SPI mode 0, MSB first, 8-bit frames.
- Samples an external SCLK/MOSI/CS into the MCU clock domain and queues received bytes in a small RX FIFO.
- Returns bytes on MISO from a one-entry TX holding register.
- Sits on the same 4-bit peripheral bus as the GPIO/SPI master block, in its own 0xfx page.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two, 2..16).

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous active-high reset
- sclk_in  input  1  external SPI clock (asynchronous)
- mosi_in  input  1  external serial data in (asynchronous)
- cs_in  input  1  external chip select, active low (asynchronous)
- miso_out  output  1  serial data out
- miso_oe_out  output  1  MISO output enable
- periph_data_out  output  8  read data
- periph_data_valid_out  output  1  read data valid
- periph_data_in  input  8  write data
- periph_addr_in  input  4  register address
- periph_addr_valid_in  input  1  bus access strobe
- periph_write_en_in  input  1  1 = write, 0 = read

Behaviour:
- Register map:
  - 0x0 RX_DATA (R): pops the FIFO head.
  - 0x1 STATUS (R): bit0 rx_not_empty, bit1 rx_full, bit2 overflow (sticky), bit3 frame_active, bit4 tx_empty; other bits 0.
  - 0x2 TX_DATA (W): loads the TX holding register.
  - 0x3 CTRL (R/W): bit0 enable; writing 1 to bit1 clears overflow (bit1 reads 0).
  - Other addresses read 0x00; writes to them are ignored.
- Bus timing:
  - Reads: periph_data_out and periph_data_valid_out update one cycle after a strobe with write_en=0.
  - valid is 0 after writes and after idle cycles.
  - A RX_DATA read while empty returns 0x00 and does not pop.
- Reset values:
  - periph_data_out 0x00, valid 0, miso_out 0, miso_oe_out 0.
  - enable 0, FIFO empty, overflow 0, tx_empty 1, bit counter 0, frame_active 0.
  - Synchronizers reset to idle: sclk 0, cs 1, mosi 0.
- Synchronisation:
  - Two-FF synchronizer on each of sclk, mosi and cs, plus one delay stage for edge detection.
  - Edges are decoded from the synchronized signals.
  - Requirement: SCLK high and low phases each last ≥4 clk_in cycles, i.e. master divider ≥3.
- Frame control (only when enable=1; with enable=0 all SCLK/CS edges are ignored and frame_active is held at 0):
  - CS falling edge: frame_active=1, bit counter=0, tx_shift loaded.
  - CS rising edge: frame_active=0; any partial byte is discarded and the bit counter cleared.
  - SCLK rising edge while frame_active: rx_shift = {rx_shift[6:0], mosi}, bit counter +1 (3-bit, wraps 7→0).
    - On the 8th edge the assembled byte is pushed.
    - If the FIFO is full, the byte is dropped and overflow is set.
  - SCLK falling edge while frame_active:
    - bit counter == 0 (byte just completed): load tx_shift.
    - Otherwise: tx_shift shifts left, filling with 1.
  - tx_shift load: takes the TX holding value if tx_empty=0, then sets tx_empty=1; otherwise loads 0xFF.
- MISO outputs:
  - miso_out = tx_shift[7] while frame_active, else 0.
  - miso_oe_out = frame_active.
- TX_DATA write:
  - Accepted only when tx_empty=1; it then clears tx_empty.
  - Ignored when tx_empty=0.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect, occupancy unchanged; a full FIFO does not overflow in that cycle.
  - 8th SCLK rise coincident with CS rise: the byte is pushed, then the frame ends.
  - TX load coincident with a TX_DATA write: the load takes the old value and the new write is accepted.
  - Overflow set and clear in the same cycle: set wins.
- Reset mid-frame: all state cleared and the partial byte is lost. If CS is held low across reset, a new frame begins on the falling edge decoded 3 cycles after reset release, provided enable has been set by then; otherwise the slave waits for the next CS fall.

Decomposition:
- Package mcu_spi_target_pkg: register address constants (RX_DATA, STATUS, TX_DATA, CTRL) and STATUS/CTRL bit-position constants.
- Sub-module mcu_sync_fifo:
  - Parameters WIDTH=8, DEPTH=RX_DEPTH.
  - Ports: push, pop, data in/out, full, empty.
  - Read-through head; pointer wrap by power-of-two masking.

Test Plan:
- Reset, write CTRL=0x01; master sends 0xA5 with divider 3 → STATUS=0x19 (not_empty, frame_active still 1 until CS rise), then after CS rise RX_DATA reads 0xA5 and STATUS=0x10.
- TX_DATA=0x3C before CS fall; send 0x00 → MISO bits 0,0,1,1,1,1,0,0 valid at each SCLK rise; a second byte in the same frame returns 0xFF.
- Five bytes 0x01..0x05 with RX_DEPTH=4 and no reads → STATUS bit2=1, reads return 0x01..0x04 then 0x00; write CTRL=0x03 clears overflow.
- CS deasserted after 5 SCLK pulses, then a full byte 0x81 → FIFO holds only 0x81, partial bits discarded.
- RX_DATA read in the same cycle as the byte push with FIFO full → no overflow, occupancy stays 4.
- enable=0 during a transfer → no push, miso_oe_out=0; reset_in pulsed mid-byte → STATUS=0x10 the cycle after release.

Source files
------------

// File: rtl/mcu_spi_target_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mcu_spi_target_pkg                                         |
// | Description : Register addresses and STATUS/CTRL bit positions for the   |
// |               memory-mapped SPI target peripheral (0xfx page).           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mcu_spi_target_pkg;

    // Register addresses (low nibble within the peripheral page)
    localparam logic [3:0] c_addr_rx_data = 4'h0;
    localparam logic [3:0] c_addr_status  = 4'h1;
    localparam logic [3:0] c_addr_tx_data = 4'h2;
    localparam logic [3:0] c_addr_ctrl    = 4'h3;

    // STATUS bit positions
    localparam int c_st_rx_not_empty = 0;
    localparam int c_st_rx_full      = 1;
    localparam int c_st_overflow     = 2;
    localparam int c_st_frame_active = 3;
    localparam int c_st_tx_empty     = 4;

    // CTRL bit positions
    localparam int c_ctrl_enable  = 0;
    localparam int c_ctrl_clr_ovf = 1;

endpackage
`default_nettype wire

// File: rtl/mcu_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mcu_sync_fifo                                              |
// | Description : Single-clock FIFO with read-through head. DEPTH must be a  |
// |               power of two; pointers wrap by masking.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk_in    - system clock                                               |
// |   reset_in  - synchronous active-high reset                              |
// |   push      - write data_in (accepted if not full, or if popping too)    |
// |   pop       - remove head entry (ignored when empty)                     |
// |   data_in   - write data                                                 |
// |   data_out  - current head entry (valid when not empty)                  |
// |   full      - all DEPTH entries occupied                                 |
// |   empty     - no entries                                                 |
// +--------------------------------------------------------------------------+
module mcu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int             c_aw       = $clog2(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_mask = c_aw'(DEPTH - 1);
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign data_out = r_mem[r_rd_ptr];

    // A push into a full FIFO is still legal when the head leaves in the same cycle
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr + 1'b1) & c_ptr_mask;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr + 1'b1) & c_ptr_mask;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcu_spi_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mcu_spi_target                                             |
// | Description : Memory-mapped SPI target (mode 0, MSB first, 8-bit). SCLK, |
// |               MOSI and CS are synchronized into clk_in; received bytes   |
// |               queue in an RX FIFO; MISO comes from a one-entry TX hold.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk_in                - system clock                                   |
// |   reset_in              - synchronous active-high reset                  |
// |   sclk_in/mosi_in/cs_in - external SPI pins (asynchronous, CS active low)|
// |   miso_out, miso_oe_out - serial data out and its output enable          |
// |   periph_*              - 4-bit address peripheral bus, registered reads |
// +--------------------------------------------------------------------------+
module mcu_spi_target
    import mcu_spi_target_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       sclk_in,
    input  logic       mosi_in,
    input  logic       cs_in,
    output logic       miso_out,
    output logic       miso_oe_out,
    output logic [7:0] periph_data_out,
    output logic       periph_data_valid_out,
    input  logic [7:0] periph_data_in,
    input  logic [3:0] periph_addr_in,
    input  logic       periph_addr_valid_in,
    input  logic       periph_write_en_in
);

    // ---------------------------------------------------------------- sync
    logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic r_cs_meta,   r_cs_sync,   r_cs_dly;
    logic r_mosi_meta, r_mosi_sync;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_dly  <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_dly    <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= sclk_in;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_dly  <= r_sclk_sync;
            r_cs_meta   <= cs_in;
            r_cs_sync   <= r_cs_meta;
            r_cs_dly    <= r_cs_sync;
            r_mosi_meta <= mosi_in;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    assign w_sclk_rise =  r_sclk_sync & ~r_sclk_dly;
    assign w_sclk_fall = ~r_sclk_sync &  r_sclk_dly;
    assign w_cs_rise   =  r_cs_sync   & ~r_cs_dly;
    assign w_cs_fall   = ~r_cs_sync   &  r_cs_dly;

    // ---------------------------------------------------------------- state
    logic       r_enable;
    logic       r_frame_active;
    logic       r_overflow;
    logic       r_tx_empty;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_hold;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;

    // ---------------------------------------------------------------- bus decode
    logic w_rd_strobe, w_wr_strobe;

    assign w_rd_strobe = periph_addr_valid_in & ~periph_write_en_in;
    assign w_wr_strobe = periph_addr_valid_in &  periph_write_en_in;

    // ---------------------------------------------------------------- FIFO
    logic       w_fifo_full, w_fifo_empty;
    logic [7:0] w_fifo_head;
    logic [7:0] w_rx_byte;
    logic       w_byte_done;
    logic       w_pop;
    logic       w_push;
    logic       w_ovf_set, w_ovf_clr;

    // The MOSI sample aligns with the decoded SCLK rise: both pass through
    // the same two synchronizer stages.
    assign w_rx_byte   = {r_rx_shift, r_mosi_sync};
    assign w_byte_done = r_enable & r_frame_active & w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_pop       = w_rd_strobe & (periph_addr_in == c_addr_rx_data) & ~w_fifo_empty;
    assign w_push      = w_byte_done & (~w_fifo_full | w_pop);
    assign w_ovf_set   = w_byte_done & w_fifo_full & ~w_pop;
    assign w_ovf_clr   = w_wr_strobe & (periph_addr_in == c_addr_ctrl)
                         & periph_data_in[c_ctrl_clr_ovf];

    mcu_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .push     (w_push),
        .pop      (w_pop),
        .data_in  (w_rx_byte),
        .data_out (w_fifo_head),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    // ---------------------------------------------------------------- TX path
    logic w_tx_load;
    logic w_tx_wr;

    // Load at frame start, and on the falling edge that follows a completed
    // byte. A falling edge coincident with CS rise is the end of the frame
    // and must not consume the holding register.
    assign w_tx_load = r_enable & (w_cs_fall
                       | (r_frame_active & ~w_cs_rise & w_sclk_fall & (r_bit_cnt == 3'd0)));
    // A load in the same cycle frees the holding register, so the write lands
    assign w_tx_wr   = w_wr_strobe & (periph_addr_in == c_addr_tx_data)
                       & (r_tx_empty | w_tx_load);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_tx_hold  <= 8'h00;
            r_tx_empty <= 1'b1;
        end else if (w_tx_wr) begin
            r_tx_hold  <= periph_data_in;
            r_tx_empty <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_empty <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- frame
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_frame_active <= 1'b0;
            r_bit_cnt      <= 3'd0;
            r_rx_shift     <= 7'h00;
            r_tx_shift     <= 8'h00;
        end else if (!r_enable) begin
            r_frame_active <= 1'b0;
            r_bit_cnt      <= 3'd0;
        end else begin
            if (w_cs_fall) begin
                r_frame_active <= 1'b1;
                r_bit_cnt      <= 3'd0;
            end else if (r_frame_active) begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                // Later assignment wins: a partial byte is dropped at CS rise
                if (w_cs_rise) begin
                    r_frame_active <= 1'b0;
                    r_bit_cnt      <= 3'd0;
                end
            end

            if (w_tx_load) begin
                r_tx_shift <= r_tx_empty ? 8'hFF : r_tx_hold;
            end else if (r_frame_active && w_sclk_fall) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
        end
    end

    // ---------------------------------------------------------------- CTRL / overflow
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_strobe && (periph_addr_in == c_addr_ctrl)) begin
                r_enable <= periph_data_in[c_ctrl_enable];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- read path
    logic [7:0] w_rd_mux;

    always_comb begin
        w_rd_mux = 8'h00;
        case (periph_addr_in)
            c_addr_rx_data: w_rd_mux = w_fifo_empty ? 8'h00 : w_fifo_head;
            c_addr_status: begin
                w_rd_mux[c_st_rx_not_empty] = ~w_fifo_empty;
                w_rd_mux[c_st_rx_full]      = w_fifo_full;
                w_rd_mux[c_st_overflow]     = r_overflow;
                w_rd_mux[c_st_frame_active] = r_frame_active;
                w_rd_mux[c_st_tx_empty]     = r_tx_empty;
            end
            c_addr_ctrl:    w_rd_mux[c_ctrl_enable] = r_enable;
            default:        w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_strobe;
            if (w_rd_strobe) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign periph_data_out       = r_rd_data;
    assign periph_data_valid_out = r_rd_valid;
    assign miso_out              = r_frame_active & r_tx_shift[7];
    assign miso_oe_out           = r_frame_active;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mcu_spi_target                                          |
// | Description : Directed self-checking bench for mcu_spi_target. Drives an |
// |               SPI master with half-periods of 4 clk_in cycles.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mcu_spi_target;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       sclk_in = 1'b0;
    logic       mosi_in = 1'b0;
    logic       cs_in = 1'b1;
    logic       miso_out;
    logic       miso_oe_out;
    logic [7:0] periph_data_out;
    logic       periph_data_valid_out;
    logic [7:0] periph_data_in = 8'h00;
    logic [3:0] periph_addr_in = 4'h0;
    logic       periph_addr_valid_in = 1'b0;
    logic       periph_write_en_in = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] A_RX = 4'h0, A_ST = 4'h1, A_TX = 4'h2, A_CT = 4'h3;

    mcu_spi_target #(.RX_DEPTH(4)) dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .sclk_in               (sclk_in),
        .mosi_in               (mosi_in),
        .cs_in                 (cs_in),
        .miso_out              (miso_out),
        .miso_oe_out           (miso_oe_out),
        .periph_data_out       (periph_data_out),
        .periph_data_valid_out (periph_data_valid_out),
        .periph_data_in        (periph_data_in),
        .periph_addr_in        (periph_addr_in),
        .periph_addr_valid_in  (periph_addr_valid_in),
        .periph_write_en_in    (periph_write_en_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        periph_addr_in       = a;
        periph_data_in       = d;
        periph_write_en_in   = 1'b1;
        periph_addr_valid_in = 1'b1;
        tick(1);
        periph_addr_valid_in = 1'b0;
        periph_write_en_in   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic v);
        periph_addr_in       = a;
        periph_write_en_in   = 1'b0;
        periph_addr_valid_in = 1'b1;
        tick(1);
        periph_addr_valid_in = 1'b0;
        d = periph_data_out;
        v = periph_data_valid_out;
    endtask

    task automatic cs_low();
        cs_in = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        cs_in = 1'b1;
        tick(6);
    endtask

    // Shifts nbits of tx MSB first; collects MISO just before each rise.
    // With rd_on_last, an RX_DATA read is timed to hit the clock edge at
    // which the last rise is decoded (third edge after SCLK goes high).
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic rd_on_last,
                            output logic [7:0] miso_seen, output logic [7:0] rd_d);
        miso_seen = 8'h00;
        rd_d      = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = tx[7-i];
            tick(4);
            miso_seen = {miso_seen[6:0], miso_out};
            sclk_in = 1'b1;
            if (rd_on_last && i == nbits - 1) begin
                tick(2);
                periph_addr_in       = A_RX;
                periph_write_en_in   = 1'b0;
                periph_addr_valid_in = 1'b1;
                tick(1);
                periph_addr_valid_in = 1'b0;
                rd_d = periph_data_out;
                tick(1);
            end else begin
                tick(4);
            end
            sclk_in = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] miso_seen);
        logic [7:0] unused_rd;
        spi_bits(tx, 8, 1'b0, miso_seen, unused_rd);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        reset_in = 1'b1;
        tick(3);
        reset_in = 1'b0;
        tick(1);
        checks++;
        if ({periph_data_out, periph_data_valid_out, miso_out, miso_oe_out} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: data=%02h valid=%b miso=%b oe=%b, want 00 0 0 0",
                     periph_data_out, periph_data_valid_out, miso_out, miso_oe_out);
        end
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10 || v !== 1'b1) begin
            errors++; $display("FAIL reset_status: got %02h valid %b, want 10 valid 1", d, v);
        end
        tick(1);
        checks++;
        if (periph_data_valid_out !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %b, want 0", periph_data_valid_out);
        end
        bus_read(A_CT, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %02h, want 00", d);
        end
        bus_read(A_RX, d, v);
        checks++;
        if (d !== 8'h00 || v !== 1'b1) begin
            errors++; $display("FAIL empty_rx_read: got %02h valid %b, want 00 valid 1", d, v);
        end
        bus_read(4'h7, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL unmapped_read: got %02h, want 00", d);
        end
    endtask

    task automatic test_basic_rx();
        logic [7:0] d, m;
        logic       v;
        bus_write(A_CT, 8'h01);
        checks++;
        if (periph_data_valid_out !== 1'b0) begin
            errors++; $display("FAIL write_valid: got %b, want 0", periph_data_valid_out);
        end
        bus_read(A_CT, d, v);
        checks++;
        if (d !== 8'h01) begin
            errors++; $display("FAIL ctrl_enable: got %02h, want 01", d);
        end
        cs_low();
        spi_byte(8'hA5, m);
        tick(4);
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h19) begin
            errors++; $display("FAIL status_in_frame: got %02h, want 19", d);
        end
        cs_high();
        bus_read(A_RX, d, v);
        checks++;
        if (d !== 8'hA5 || v !== 1'b1) begin
            errors++; $display("FAIL rx_a5: got %02h valid %b, want a5 valid 1", d, v);
        end
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL status_after_pop: got %02h, want 10", d);
        end
    endtask

    task automatic test_tx_miso();
        logic [7:0] d, m;
        logic       v;
        bus_write(A_TX, 8'h3C);
        bus_write(A_TX, 8'h55);   // holding register busy: must be ignored
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL status_tx_full: got %02h, want 00", d);
        end
        cs_low();
        checks++;
        if (miso_oe_out !== 1'b1) begin
            errors++; $display("FAIL miso_oe_frame: got %b, want 1", miso_oe_out);
        end
        spi_byte(8'h00, m);
        checks++;
        if (m !== 8'h3C) begin
            errors++; $display("FAIL miso_byte1: got %02h, want 3c", m);
        end
        spi_byte(8'h00, m);
        checks++;
        if (m !== 8'hFF) begin
            errors++; $display("FAIL miso_byte2: got %02h, want ff", m);
        end
        cs_high();
        checks++;
        if (miso_oe_out !== 1'b0 || miso_out !== 1'b0) begin
            errors++; $display("FAIL miso_idle: oe=%b miso=%b, want 0 0", miso_oe_out, miso_out);
        end
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h11) begin
            errors++; $display("FAIL status_two_bytes: got %02h, want 11", d);
        end
        bus_read(A_RX, d, v);
        bus_read(A_RX, d, v);
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL status_drained: got %02h, want 10", d);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d, m;
        logic       v;
        cs_low();
        for (int b = 1; b <= 5; b++) spi_byte(8'(b), m);
        cs_high();
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h17) begin
            errors++; $display("FAIL status_overflow: got %02h, want 17", d);
        end
        for (int b = 1; b <= 5; b++) begin
            bus_read(A_RX, d, v);
            checks++;
            if (d !== ((b <= 4) ? 8'(b) : 8'h00)) begin
                errors++; $display("FAIL ovf_read%0d: got %02h, want %02h", b, d,
                                   (b <= 4) ? 8'(b) : 8'h00);
            end
        end
        bus_write(A_CT, 8'h03);
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL overflow_clear: got %02h, want 10", d);
        end
        bus_read(A_CT, d, v);
        checks++;
        if (d !== 8'h01) begin
            errors++; $display("FAIL ctrl_bit1_reads0: got %02h, want 01", d);
        end
    endtask

    task automatic test_partial();
        logic [7:0] d, m, r;
        logic       v;
        cs_low();
        spi_bits(8'hFF, 5, 1'b0, m, r);
        cs_high();
        cs_low();
        spi_byte(8'h81, m);
        cs_high();
        bus_read(A_RX, d, v);
        checks++;
        if (d !== 8'h81) begin
            errors++; $display("FAIL partial_discard: got %02h, want 81", d);
        end
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL partial_single: got %02h, want 10", d);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d, m, r;
        logic       v;
        cs_low();
        for (int b = 0; b < 4; b++) spi_byte(8'h11 + 8'(b), m);
        spi_bits(8'h15, 8, 1'b1, m, r);
        checks++;
        if (r !== 8'h11) begin
            errors++; $display("FAIL pop_at_push: got %02h, want 11", r);
        end
        cs_high();
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h13) begin
            errors++; $display("FAIL full_no_overflow: got %02h, want 13", d);
        end
        for (int b = 0; b < 4; b++) begin
            bus_read(A_RX, d, v);
            checks++;
            if (d !== 8'h12 + 8'(b)) begin
                errors++; $display("FAIL full_drain%0d: got %02h, want %02h", b, d, 8'h12 + 8'(b));
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] d, m, r;
        logic       v;
        cs_low();
        spi_bits(8'hAA, 4, 1'b0, m, r);
        bus_write(A_CT, 8'h00);
        tick(1);
        checks++;
        if (miso_oe_out !== 1'b0) begin
            errors++; $display("FAIL disable_oe: got %b, want 0", miso_oe_out);
        end
        spi_bits(8'hAA, 4, 1'b0, m, r);
        spi_byte(8'h5A, m);
        cs_high();
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL disable_no_push: got %02h, want 10", d);
        end
        bus_write(A_CT, 8'h01);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, m, r;
        logic       v;
        cs_low();
        spi_bits(8'hC3, 3, 1'b0, m, r);
        reset_in = 1'b1;
        tick(1);
        reset_in = 1'b0;
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10 || v !== 1'b1) begin
            errors++; $display("FAIL reset_mid_status: got %02h valid %b, want 10 valid 1", d, v);
        end
        tick(6);
        bus_read(A_ST, d, v);
        checks++;
        if (d !== 8'h10 || miso_oe_out !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_frame: got %02h oe %b, want 10 oe 0", d, miso_oe_out);
        end
        cs_in = 1'b1;
        tick(6);
    endtask

    initial begin
        test_reset();
        test_basic_rx();
        test_tx_miso();
        test_overflow();
        test_partial();
        test_push_pop_full();
        test_disable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
